data_mem_ctrl: RTL

Parametrised, handshaked data memory for the single-cycle core's load/store path and the UART-side bus master. Replaces a combinational-read byte array with a request/response interface, programmable wait states, byte/half/word stores with byte lanes, and sign/zero-extended loads. It sits between the core's load-store unit and the byte-addressed data store.

---
 rtl/data_mem_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - handshaked byte-lane data memory with wait states (optional MEM_MISALIGN_TRAP_EN)
module data_mem_ctrl #(
    parameter int BYTE_SIZE   = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [BYTE_SIZE*8-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [BYTE_SIZE*8-1:0] rsp_rdata,
    output logic                   rsp_err
);
    localparam int DW         = BYTE_SIZE * 8;
    localparam int HB         = DW / 2;
    localparam int HALF_BYTES = BYTE_SIZE / 2;
    localparam int IW         = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_d;
    logic [3:0]      cnt;
    logic            do_access;
    logic            fault;

    logic            lat_we, lat_uns;
    logic [1:0]      lat_size;
    logic [IW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;

    logic            a_we, a_uns;
    logic [1:0]      a_size;
    logic [IW-1:0]   a_addr;
    logic [DW-1:0]   a_wdata;

    logic [7:0]      mem [DEPTH];
    logic [DW-1:0]   rword, load_data, fill_h, fill_b;
    int              nbytes;
    logic            unused_addr_hi;

    // Only addr mod DEPTH selects a byte; the upper address bits are intentionally ignored.
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:IW];

    // With zero wait states the access happens on the accept edge, so it uses the live request fields.
    assign a_we    = (state == IDLE) ? req_we            : lat_we;
    assign a_uns   = (state == IDLE) ? req_unsigned      : lat_uns;
    assign a_size  = (state == IDLE) ? req_size          : lat_size;
    assign a_addr  = (state == IDLE) ? req_addr[IW-1:0]  : lat_addr;
    assign a_wdata = (state == IDLE) ? req_wdata         : lat_wdata;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam int HL = $clog2(HALF_BYTES);
    localparam int WL = $clog2(BYTE_SIZE);
    assign fault = ((a_size == 2'b10) && (a_addr[HL-1:0] != '0)) ||
                   ((a_size == 2'b01 || a_size == 2'b00) && (a_addr[WL-1:0] != '0));
`else
    assign fault = 1'b0;
`endif

    // Next-state decode, handshake outputs and the access strobe.
    always_comb begin
        state_d   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                        state_d   = RESP;
                    end else begin
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = RESP == RESP ? IDLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Number of bytes touched by the current access; reserved size behaves as a word.
    always_comb begin
        nbytes = BYTE_SIZE;
        case (a_size)
            2'b10:   nbytes = HALF_BYTES;
            2'b11:   nbytes = 1;
            default: nbytes = BYTE_SIZE;
        endcase
    end

    // Little-endian gather with wrap-around at the top of the array.
    always_comb begin
        rword = '0;
        for (int k = 0; k < BYTE_SIZE; k++) begin
            rword[8*k +: 8] = mem[a_addr + IW'(k)];
        end
    end

    assign fill_h = (a_uns || !rword[HB-1]) ? '0 : '1;
    assign fill_b = (a_uns || !rword[7])    ? '0 : '1;

    // Sign- or zero-extend half and byte loads into the full data width.
    always_comb begin
        load_data = rword;
        case (a_size)
            2'b10:   load_data = {fill_h[DW-1:HB], rword[HB-1:0]};
            2'b11:   load_data = {fill_b[DW-1:8], rword[7:0]};
            default: load_data = rword;
        endcase
    end

    // State register, wait counter, request field latches and the response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_uns   <= req_unsigned;
                lat_size  <= req_size;
                lat_addr  <= req_addr[IW-1:0];
                lat_wdata <= req_wdata;
                cnt       <= 4'(WAIT_STATES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rsp_rdata <= (fault || a_we) ? '0 : load_data;
                rsp_err   <= fault;
            end
        end
    end

    // Byte-lane store; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_access && a_we && !fault) begin
            for (int k = 0; k < BYTE_SIZE; k++) begin
                if (k < nbytes) mem[a_addr + IW'(k)] <= a_wdata[8*k +: 8];
            end
        end
    end
endmodule
